// File: rtl/xor_rr_scheduler.sv
// Round-robin scheduler sharing one registered XOR unit between NREQ requesters.
// Optional XOR_RR_SCHED_PARITY_EN adds rsp_parity, the registered reduction XOR of rsp_data.
module xor_rr_scheduler #(
  parameter int  NREQ  = 4,
  parameter int  WIDTH = 8,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
`ifdef XOR_RR_SCHED_PARITY_EN
  output logic                  rsp_parity,
`endif
  output logic [15:0]           done_cnt
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   cand;
  logic             found;
  logic             grant;
  logic             rsp_fire;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH-1:0] xor_p0;

  // Rotating priority: the search starts just after the last winner.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    cand   = rr_ptr;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xor_p0   = sel_a ^ sel_b;
  assign grant    = |(req_valid & req_ready);
  assign rsp_fire = (state == RESP) && rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant)    state_nxt = RESP;
      RESP:    if (rsp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Held low during reset so no requester sees an accept while the block is down.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == IDLE) && found) req_ready[winner] = 1'b1;
  end

  // Stage boundary: operands of the accepted request become the registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rr_ptr    <= IDW'(NREQ - 1);
      done_cnt  <= '0;
`ifdef XOR_RR_SCHED_PARITY_EN
      rsp_parity <= 1'b0;
`endif
    end else begin
      if (grant) begin
        rsp_valid <= 1'b1;
        rsp_data  <= xor_p0;
        rsp_id    <= winner;
        rr_ptr    <= winner;
`ifdef XOR_RR_SCHED_PARITY_EN
        rsp_parity <= ^xor_p0;
`endif
      end else if (rsp_fire) begin
        rsp_valid <= 1'b0;
        done_cnt  <= done_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_xor_rr_scheduler.sv
// Directed bench for xor_rr_scheduler: vector table plus hand sequences for
// backpressure, asynchronous reset in RESP and done_cnt wrap.
module tb_xor_rr_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic [15:0] done_cnt;
`ifdef XOR_RR_SCHED_PARITY_EN
  logic        rsp_parity;
`endif

  xor_rr_scheduler #(.NREQ(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
`ifdef XOR_RR_SCHED_PARITY_EN
    .rsp_parity(rsp_parity),
`endif
    .done_cnt  (done_cnt)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ready;
    logic [7:0]  data;
    logic [1:0]  id;
  } vec_t;

  vec_t        vecs[12];
  int          total = 0;
  int          passed = 0;
  logic [15:0] exp_cnt = 16'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  // Called at a falling edge; returns at the falling edge after the response handshake.
  task automatic txn(input vec_t v);
    req_valid = v.valid;
    req_a     = v.a;
    req_b     = v.b;
    rsp_ready = 1'b1;
    #1 chk("req_ready", req_ready, v.ready);
    @(negedge clk);
    req_valid = 4'b0000;
    chk("rsp_valid_set", rsp_valid, 1'b1);
    chk("rsp_data", rsp_data, v.data);
    chk("rsp_id", rsp_id, v.id);
`ifdef XOR_RR_SCHED_PARITY_EN
    chk("rsp_parity", rsp_parity, ^v.data);
`endif
    @(negedge clk);
    exp_cnt++;
    chk("rsp_valid_clr", rsp_valid, 1'b0);
    chk("done_cnt", done_cnt, exp_cnt);
  endtask

  initial begin
    // Round robin over all four with bit-0 truth table 00/01/10/11 -> 0,1,1,0
    vecs[0]  = '{4'b1111, 32'h01010000, 32'h01000100, 4'b0001, 8'h00, 2'd0};
    vecs[1]  = '{4'b1111, 32'h01010000, 32'h01000100, 4'b0010, 8'h01, 2'd1};
    vecs[2]  = '{4'b1111, 32'h01010000, 32'h01000100, 4'b0100, 8'h01, 2'd2};
    vecs[3]  = '{4'b1111, 32'h01010000, 32'h01000100, 4'b1000, 8'h00, 2'd3};
    vecs[4]  = '{4'b1111, 32'h01010000, 32'h01000100, 4'b0001, 8'h00, 2'd0};
    vecs[5]  = '{4'b0100, 32'h00A50000, 32'h000F0000, 4'b0100, 8'hAA, 2'd2};
    vecs[6]  = '{4'b0011, 32'h000000F0, 32'h0000003C, 4'b0001, 8'hCC, 2'd0};
    vecs[7]  = '{4'b1001, 32'h12000000, 32'h34000000, 4'b1000, 8'h26, 2'd3};
    vecs[8]  = '{4'b1010, 32'h0000FF00, 32'h00000000, 4'b0010, 8'hFF, 2'd1};
    vecs[9]  = '{4'b0110, 32'h00550000, 32'h000F0000, 4'b0100, 8'h5A, 2'd2};
    vecs[10] = '{4'b1011, 32'hA0000000, 32'h0B000000, 4'b1000, 8'hAB, 2'd3};
    vecs[11] = '{4'b0110, 32'h00007700, 32'h00007000, 4'b0010, 8'h07, 2'd1};

    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_a     = 32'h01010000;
    req_b     = 32'h01000100;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_req_ready", req_ready, 4'b0000);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_done_cnt", done_cnt, 16'h0000);
    chk("reset_rsp_data", rsp_data, 8'h00);
    chk("reset_rsp_id", rsp_id, 2'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) txn(vecs[i]);

    // No requests: stays idle
    req_valid = 4'b0000;
    #1 chk("idle_req_ready", req_ready, 4'b0000);
    @(negedge clk);
    chk("idle_rsp_valid", rsp_valid, 1'b0);
    chk("idle_done_cnt", done_cnt, exp_cnt);

    // Backpressure: response held for 5 cycles; valids changed in RESP are ignored
    req_valid = 4'b0001;
    req_a     = 32'h0000003C;
    req_b     = 32'h0000000F;
    rsp_ready = 1'b0;
    #1 chk("bp_req_ready", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'b1111;
    req_a     = 32'h00007700;
    req_b     = 32'h00007000;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_rsp_data", rsp_data, 8'h33);
      chk("bp_rsp_id", rsp_id, 2'd0);
      chk("bp_req_ready", req_ready, 4'b0000);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    exp_cnt++;
    chk("bp_release_valid", rsp_valid, 1'b0);
    chk("bp_release_cnt", done_cnt, exp_cnt);
    chk("bp_next_ready", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = 4'b0000;
    chk("bp_next_data", rsp_data, 8'h07);
    chk("bp_next_id", rsp_id, 2'd1);
    @(negedge clk);
    exp_cnt++;
    chk("bp_next_cnt", done_cnt, exp_cnt);

    // Asynchronous reset while a response is pending
    req_valid = 4'b0100;
    req_a     = 32'h00110000;
    req_b     = 32'h00000000;
    rsp_ready = 1'b0;
    #1 chk("ar_req_ready", req_ready, 4'b0100);
    @(negedge clk);
    chk("ar_rsp_valid_before", rsp_valid, 1'b1);
    chk("ar_rsp_data_before", rsp_data, 8'h11);
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 16'h0000;
    chk("ar_rsp_valid", rsp_valid, 1'b0);
    chk("ar_rsp_data", rsp_data, 8'h00);
    chk("ar_done_cnt", done_cnt, exp_cnt);
    chk("ar_req_ready", req_ready, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    txn('{4'b1111, 32'h0000005A, 32'h00000000, 4'b0001, 8'h5A, 2'd0});

    // Counter wrap: preload near the top, then two handshakes
    force dut.done_cnt = 16'hFFFE;
    #1 release dut.done_cnt;
    exp_cnt = 16'hFFFE;
    @(negedge clk);
    txn('{4'b0010, 32'h0000AA00, 32'h00000000, 4'b0010, 8'hAA, 2'd1});
    txn('{4'b0100, 32'h00AB0000, 32'h00000000, 4'b0100, 8'hAB, 2'd2});
    chk("wrap_zero", done_cnt, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
